wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Writeback stage of the pipelined RV32I core; sits directly upstream of the register file.
- Holds one instruction handed over from the MEM stage.
- Waits for the data-memory response when the instruction is a load, and extracts/extends the load data.
- Selects the writeback value and drives the register file write port (load/dest/in), plus a forwarding copy for the hazard unit.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  MEM stage presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_rd  in  5  destination register.
- in_regwrite  in  1  instruction writes rd.
- in_wbsel  in  2  00 ALU, 01 load data, 10 PC+4, 11 reserved (treated as ALU).
- in_alu_out  in  32  ALU result / effective address.
- in_pc  in  32  instruction PC.
- in_funct3  in  3  load width/sign code.
- dmem_resp  in  1  data memory read data valid.
- dmem_rdata  in  32  data memory read word (aligned).
- rf_load  out  1  register file write enable.
- rf_dest  out  5  register file write index.
- rf_in  out  32  register file write data.
- load_pending  out  1  occupied by a load still awaiting dmem_resp.
- pending_rd  out  5  rd of the held instruction (valid when load_pending).

Behaviour:
- Clock/reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- States:
  - EMPTY: nothing held.
  - HOLD: non-load held.
  - WAIT_MEM: load (wbsel=01) held, awaiting response.
- Handshake:
  - Transfer when in_valid and in_ready at a posedge.
  - in_ready = (state==EMPTY) or commit.
- Commit (combinational, this cycle):
  - In HOLD: commit is unconditional.
  - In WAIT_MEM: commit only when dmem_resp=1.
  - No commit in EMPTY.
- Transitions:
  - On transfer: next state = WAIT_MEM if in_wbsel==01, else HOLD.
  - On commit without transfer: next state = EMPTY.
  - On commit with transfer in the same cycle: the new instruction is captured (back-to-back, no bubble).
  - In WAIT_MEM with dmem_resp=0: stay; in_ready=0.
- Register file write:
  - rf_load = commit & regwrite & (rd!=0).
  - rf_dest = held rd.
  - rf_in is the selected value.
  - The regfile samples at the posedge ending the commit cycle.
  - Latency: non-load accepted at edge N is written at edge N+1. A load is written at the edge ending the first cycle with dmem_resp=1.
- rf_dest/rf_in when rf_load=0: hold the last held-register values; do not care.
- Writeback value:
  - 00/11: alu_out.
  - 10: pc+4, modulo 2^32 (pc=0xFFFFFFFC gives 0).
  - 01: extracted load data.
- Load extraction, using addr = held alu_out[1:0]:
  - 000 LB: byte addr, sign-extended.
  - 100 LBU: byte addr, zero-extended.
  - 001 LH: halfword addr[1], sign-extended.
  - 101 LHU: halfword addr[1], zero-extended.
  - 010 LW: full word.
  - 011/110/111: treated as LW.
  - addr[0] is ignored for halfwords; no misalignment trap in this stage.
- Load data path: dmem_rdata flows combinationally to rf_in in the response cycle; it is not registered.
- dmem_resp in EMPTY or HOLD: ignored (stale response, e.g. after reset).
- Pending outputs:
  - load_pending = (state==WAIT_MEM) & ~dmem_resp.
  - pending_rd = held rd.
- Reset values:
  - state=EMPTY; held rd=0, regwrite=0, wbsel=00, alu_out=0, pc=0, funct3=0.
  - Outputs: rf_load=0, load_pending=0, in_ready=1.
  - Reset mid-load discards the held instruction; no register write occurs.

Optional Feature:
- Macro: WB_INSTRET_EN.
- Defined:
  - Adds output port instret (64 bits), the retired-instruction counter.
  - Increments by 1 on every commit, including rd=0 and regwrite=0.
  - Reset to 0; wraps from 2^64-1 to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- ALU op: in_valid=1, rd=5, regwrite=1, wbsel=00, alu_out=0x12345678 at edge N -> cycle after N: rf_load=1, rf_dest=5, rf_in=0x12345678; in_ready=1 throughout.
- LB sign-extend: wbsel=01, funct3=000, alu_out=0x1003, rd=7, dmem_resp held low 3 cycles -> load_pending=1, pending_rd=7, in_ready=0 for 3 cycles. Then dmem_resp=1, dmem_rdata=0x80FFFFFF -> rf_in=0xFFFFFF80, rf_load=1. Repeat with LHU, addr=2, rdata=0xBEEF0000 -> rf_in=0x0000BEEF.
- rd=0 / JAL: rd=0, regwrite=1, wbsel=10, pc=0x100 -> rf_load=0, state returns to EMPTY. Then rd=1, wbsel=10, pc=0xFFFFFFFC -> rf_in=0x00000000.
- Back-to-back: in_valid held high for 4 non-load instructions rd=1..4 -> writes on 4 consecutive edges, no bubbles. A load followed by an ALU op -> ALU op accepted in the dmem_resp cycle.
- Reset mid-load: assert rst asynchronously while in WAIT_MEM -> rf_load and load_pending go 0 immediately. After release, a late dmem_resp=1 produces no write; in_ready=1.
- WB_INSTRET_EN: 10 commits, including 2 with rd=0 -> instret=10. Force counter to 2^64-1, then one commit -> instret=0.

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage: holds one instruction from MEM, waits for load data, drives the regfile port.
// Optional retired-instruction counter enabled with `define WB_INSTRET_EN.
module wb_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rd,
  input  logic            in_regwrite,
  input  logic [1:0]      in_wbsel,
  input  logic [XLEN-1:0] in_alu_out,
  input  logic [XLEN-1:0] in_pc,
  input  logic [2:0]      in_funct3,
  input  logic            dmem_resp,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            rf_load,
  output logic [4:0]      rf_dest,
  output logic [XLEN-1:0] rf_in,
  output logic            load_pending,
`ifdef WB_INSTRET_EN
  output logic [63:0]     instret,
`endif
  output logic [4:0]      pending_rd
);

  typedef enum logic [1:0] {StEmpty, StHold, StWaitMem} state_e;

  state_e            state_q;
  logic [4:0]        rd_q;
  logic              regwrite_q;
  logic [1:0]        wbsel_q;
  logic [XLEN-1:0]   alu_q;
  logic [XLEN-1:0]   pc_q;
  logic [2:0]        funct3_q;

  logic              commit;
  logic              xfer;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [XLEN-1:0]   load_data;

  assign commit   = (state_q == StHold) || ((state_q == StWaitMem) && dmem_resp);
  assign in_ready = (state_q == StEmpty) || commit;
  assign xfer     = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StEmpty;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      wbsel_q    <= 2'b00;
      alu_q      <= '0;
      pc_q       <= '0;
      funct3_q   <= '0;
    end else if (xfer) begin
      state_q    <= (in_wbsel == 2'b01) ? StWaitMem : StHold;
      rd_q       <= in_rd;
      regwrite_q <= in_regwrite;
      wbsel_q    <= in_wbsel;
      alu_q      <= in_alu_out;
      pc_q       <= in_pc;
      funct3_q   <= in_funct3;
    end else if (commit) begin
      state_q    <= StEmpty;
    end
  end

  // Load data comes straight from the bus in the response cycle; nothing is registered.
  always_comb begin
    byte_sel = 8'h00;
    unique case (alu_q[1:0])
      2'd0: byte_sel = dmem_rdata[7:0];
      2'd1: byte_sel = dmem_rdata[15:8];
      2'd2: byte_sel = dmem_rdata[23:16];
      2'd3: byte_sel = dmem_rdata[31:24];
      default: byte_sel = 8'h00;
    endcase
    half_sel = alu_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_data = {24'h000000, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_data = {16'h0000, half_sel};
      default: load_data = dmem_rdata;
    endcase
  end

  always_comb begin
    case (wbsel_q)
      2'b01:   rf_in = load_data;
      2'b10:   rf_in = pc_q + XLEN'(4);
      default: rf_in = alu_q;
    endcase
  end

  assign rf_load      = commit && regwrite_q && (rd_q != 5'd0);
  assign rf_dest      = rd_q;
  assign load_pending = (state_q == StWaitMem) && !dmem_resp;
  assign pending_rd   = rd_q;

`ifdef WB_INSTRET_EN
  logic [63:0] instret_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_q <= '0;
    end else if (commit) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: per-cycle vector table plus reset and counter sequences.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_regwrite;
  logic [1:0]  in_wbsel;
  logic [31:0] in_alu_out;
  logic [31:0] in_pc;
  logic [2:0]  in_funct3;
  logic        dmem_resp;
  logic [31:0] dmem_rdata;
  logic        rf_load;
  logic [4:0]  rf_dest;
  logic [31:0] rf_in;
  logic        load_pending;
  logic [4:0]  pending_rd;
`ifdef WB_INSTRET_EN
  logic [63:0] instret;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_stage #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_rd       (in_rd),
    .in_regwrite (in_regwrite),
    .in_wbsel    (in_wbsel),
    .in_alu_out  (in_alu_out),
    .in_pc       (in_pc),
    .in_funct3   (in_funct3),
    .dmem_resp   (dmem_resp),
    .dmem_rdata  (dmem_rdata),
    .rf_load     (rf_load),
    .rf_dest     (rf_dest),
    .rf_in       (rf_in),
    .load_pending(load_pending),
`ifdef WB_INSTRET_EN
    .instret     (instret),
`endif
    .pending_rd  (pending_rd)
  );

  typedef struct {
    logic        valid;
    logic [4:0]  rd;
    logic        rw;
    logic [1:0]  wbsel;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [2:0]  f3;
    logic        resp;
    logic [31:0] rdata;
    logic        e_ready;
    logic        e_load;
    logic [4:0]  e_dest;
    logic [31:0] e_in;
    logic        e_pend;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t v(input logic valid, input logic [4:0] rd, input logic rw,
                             input logic [1:0] wbsel, input logic [31:0] alu,
                             input logic [31:0] pc, input logic [2:0] f3, input logic resp,
                             input logic [31:0] rdata, input logic e_ready, input logic e_load,
                             input logic [4:0] e_dest, input logic [31:0] e_in,
                             input logic e_pend);
    vec_t r;
    r.valid = valid; r.rd = rd; r.rw = rw; r.wbsel = wbsel; r.alu = alu; r.pc = pc;
    r.f3 = f3; r.resp = resp; r.rdata = rdata; r.e_ready = e_ready; r.e_load = e_load;
    r.e_dest = e_dest; r.e_in = e_in; r.e_pend = e_pend;
    return r;
  endfunction

  task automatic drive(input vec_t x);
    in_valid    = x.valid;
    in_rd       = x.rd;
    in_regwrite = x.rw;
    in_wbsel    = x.wbsel;
    in_alu_out  = x.alu;
    in_pc       = x.pc;
    in_funct3   = x.f3;
    dmem_resp   = x.resp;
    dmem_rdata  = x.rdata;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t idle;
    idle = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    drive(idle);
    rst = 1'b1;
    #12;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_rf_load", rf_load, 0);
    chk("reset_load_pending", load_pending, 0);
    chk("reset_pending_rd", pending_rd, 0);
    next_cycle();
    rst = 1'b0;

    // valid rd rw wbsel alu pc f3 resp rdata | ready load dest in pend
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFFFFFF, 1, 0, 0, 0, 0));
    vecs.push_back(v(1, 5, 1, 0, 32'h12345678, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5, 32'h12345678, 0));
    vecs.push_back(v(1, 7, 1, 1, 32'h1003, 0, 3'b000, 0, 0, 1, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 1));
    vecs.push_back(v(1, 8, 1, 1, 32'h2, 0, 3'b101, 1, 32'h80FFFFFF, 1, 1, 7, 32'hFFFFFF80, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8, 0, 1));
    vecs.push_back(v(1, 9, 1, 0, 32'hA5A5, 0, 0, 1, 32'hBEEF0000, 1, 1, 8, 32'h0000BEEF, 0));
    vecs.push_back(v(1, 0, 1, 2, 0, 32'h100, 0, 0, 0, 1, 1, 9, 32'hA5A5, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 32'h12345678, 1, 0, 0, 0, 0));
    vecs.push_back(v(1, 1, 1, 2, 0, 32'hFFFFFFFC, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h00000000, 0));
    vecs.push_back(v(1, 10, 1, 1, 32'h0, 0, 3'b001, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(v(1, 11, 1, 1, 32'h2, 0, 3'b100, 1, 32'h12348001, 1, 1, 10, 32'hFFFF8001, 0));
    vecs.push_back(v(1, 12, 1, 1, 32'h1, 0, 3'b010, 1, 32'h11AB2233, 1, 1, 11, 32'h000000AB, 0));
    vecs.push_back(v(1, 13, 1, 1, 32'h3, 0, 3'b111, 1, 32'hDEADBEEF, 1, 1, 12, 32'hDEADBEEF, 0));
    vecs.push_back(v(1, 14, 0, 3, 32'h55, 0, 0, 1, 32'hCAFEF00D, 1, 1, 13, 32'hCAFEF00D, 0));
    vecs.push_back(v(1, 15, 1, 1, 32'h3, 0, 3'b001, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 32'h7FFF0000, 1, 1, 15, 32'h00007FFF, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(v(1, 1, 1, 0, 32'h11, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(v(1, 2, 1, 0, 32'h22, 0, 0, 0, 0, 1, 1, 1, 32'h11, 0));
    vecs.push_back(v(1, 3, 1, 0, 32'h33, 0, 0, 0, 0, 1, 1, 2, 32'h22, 0));
    vecs.push_back(v(1, 4, 1, 0, 32'h44, 0, 0, 0, 0, 1, 1, 3, 32'h33, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4, 32'h44, 0));
    vecs.push_back(v(1, 16, 1, 3, 32'h77, 32'h500, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 16, 32'h77, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(negedge clk);
      chk($sformatf("v%0d_in_ready", i), in_ready, vecs[i].e_ready);
      chk($sformatf("v%0d_rf_load", i), rf_load, vecs[i].e_load);
      chk($sformatf("v%0d_load_pending", i), load_pending, vecs[i].e_pend);
      if (vecs[i].e_load) begin
        chk($sformatf("v%0d_rf_dest", i), rf_dest, vecs[i].e_dest);
        chk($sformatf("v%0d_rf_in", i), rf_in, vecs[i].e_in);
      end
      if (vecs[i].e_pend) chk($sformatf("v%0d_pending_rd", i), pending_rd, vecs[i].e_dest);
      next_cycle();
    end

    // Asynchronous reset while a load sits in WAIT_MEM with its response arriving.
    drive(v(1, 20, 1, 1, 32'h0, 0, 3'b010, 0, 0, 1, 0, 0, 0, 0));
    next_cycle();
    drive(idle);
    #2;
    chk("rst_mid_pending_before", load_pending, 1);
    chk("rst_mid_pending_rd", pending_rd, 20);
    dmem_resp  = 1'b1;
    dmem_rdata = 32'h01020304;
    #1;
    chk("rst_mid_load_before", rf_load, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_load_after", rf_load, 0);
    chk("rst_mid_pending_after", load_pending, 0);
    chk("rst_mid_ready_after", in_ready, 1);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("late_resp_no_write", rf_load, 0);
    chk("late_resp_ready", in_ready, 1);
    chk("late_resp_pending", load_pending, 0);
    next_cycle();

`ifdef WB_INSTRET_EN
    rst = 1'b1;
    #1;
    chk("instret_reset", instret, 0);
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(v(1, (i == 3 || i == 7) ? 5'd0 : 5'(i + 1), 1, 0, 32'(i), 0, 0, 0, 0,
              1, 0, 0, 0, 0));
      next_cycle();
    end
    drive(idle);
    next_cycle();
    @(negedge clk);
    chk("instret_ten", instret, 64'd10);
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    next_cycle();
    chk("instret_forced", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    drive(v(1, 3, 1, 0, 32'h9, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    next_cycle();
    drive(idle);
    next_cycle();
    @(negedge clk);
    chk("instret_wrap", instret, 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
